byte_packet_assembler: RTL

Upstream stage of the network source. Collects a host byte stream (from the UART/host receive path) into fixed-width instruction packets of PKT_WIDTH bits, MSB byte first. Completed packets are buffered in a small FIFO and presented on a valid/ready interface that connects directly to the source's `src_valid`/`src_ready`/`src` ports. Also provides a synchronous flush, so the host can resynchronise after a framing error without a global reset.

---
 rtl/byte_packet_assembler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/byte_packet_assembler.sv
// Packs a host byte stream, MSB byte first, into PKT_WIDTH-bit packets and buffers completed
// packets in a small FIFO behind a valid/ready output port. A synchronous flush drops any partial packet.
module byte_packet_assembler #(
    parameter int unsigned PKT_WIDTH  = 24,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PKT_WIDTH-1:0] out_data,
    output logic                 busy
);
    localparam int unsigned PKT_BYTES = (PKT_WIDTH + 7) / 8;
    localparam int unsigned IDX_W     = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
    // Only the low PKT_WIDTH-8 bits of the accumulator can reach a packet; the pad bits
    // of the first byte are never stored.
    localparam int unsigned ACC_W     = (PKT_WIDTH > 8) ? PKT_WIDTH - 8 : 1;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(PKT_BYTES - 1);
    localparam logic [PTR_W-1:0] LastPtr = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(FIFO_DEPTH);

    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [PTR_W-1:0]     wr_q, wr_d;
    logic [PTR_W-1:0]     rd_q, rd_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PKT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PKT_WIDTH-1:0] mem_d [FIFO_DEPTH];

    logic [PKT_WIDTH-1:0] packet;
    logic                 last_byte;
    logic                 accept;
    logic                 push;
    logic                 pop;

    if (PKT_BYTES == 1) begin : g_single
        assign packet = in_data[PKT_WIDTH-1:0];
    end else begin : g_multi
        assign packet = {acc_q, in_data};
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LastPtr) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        last_byte = (byte_idx_q == LastIdx);
        // Registered-state only: a pop in a full cycle frees space from the next cycle on.
        in_ready  = !last_byte || (count_q < FullCnt);
        accept    = in_valid && in_ready;
        push      = accept && !flush && last_byte;
        pop       = (count_q != '0) && out_ready;
        out_valid = (count_q != '0);
        out_data  = mem_q[rd_q];
        busy      = (byte_idx_q != '0);
    end

    always_comb begin
        acc_d      = acc_q;
        byte_idx_d = byte_idx_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        mem_d      = mem_q;

        if (flush) begin
            acc_d      = '0;
            byte_idx_d = '0;
        end else if (accept) begin
            if (last_byte) begin
                acc_d        = '0;
                byte_idx_d   = '0;
                mem_d[wr_q]  = packet;
                wr_d         = ptr_inc(wr_q);
            end else begin
                acc_d      = packet[ACC_W-1:0];
                byte_idx_d = byte_idx_q + IDX_W'(1);
            end
        end

        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            acc_q      <= '0;
            byte_idx_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            acc_q      <= acc_d;
            byte_idx_q <= byte_idx_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

endmodule
